// File: rtl/cobra_pkg.sv
// Shared fetch definitions: default widths, the halt encoding and the fetch state type.
package cobra_pkg;

   localparam int unsigned ADDR_W_DEF = 8;
   localparam int unsigned DATA_W_DEF = 32;
   localparam logic [31:0] HALT_WORD  = 32'hFFFF_FFFF;

   typedef enum logic [0:0] {
      ST_FETCH = 1'b0,
      ST_HALT  = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Single-cycle instruction fetch with a one-entry output slot, branch redirect/flush,
// and an optional halt-on-all-ones-word mode enabled by FETCH_HALT_DETECT_EN.
module fetch_ctrl
   import cobra_pkg::*;
#(
   parameter int unsigned          ADDR_W   = ADDR_W_DEF,
   parameter int unsigned          DATA_W   = DATA_W_DEF,
   parameter logic [ADDR_W-1:0]    RESET_PC = {ADDR_W{1'b0}}
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic [DATA_W-1:0]   imem_rd,
   input  logic                branch_valid,
   input  logic [ADDR_W-1:0]   branch_target,
   output logic                instr_valid,
   input  logic                instr_ready,
   output logic [DATA_W-1:0]   instr_data,
   output logic [ADDR_W-1:0]   instr_pc,
   output logic                halted,
   input  logic                resume
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              instr_valid_q, instr_valid_d;
   logic [DATA_W-1:0] instr_data_q, instr_data_d;
   logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
   logic              slot_free_s;
   logic [ADDR_W-1:0] pc_inc_s;

`ifdef FETCH_HALT_DETECT_EN
   fetch_state_e      state_q, state_d;
   logic              halted_q, halted_d;
   logic              is_halt_s;

   assign is_halt_s = (imem_rd == {DATA_W{1'b1}});
   assign halted    = halted_q;
`else
   logic              unused_resume_s;

   assign unused_resume_s = resume;
   assign halted          = 1'b0;
`endif

   assign slot_free_s = !instr_valid_q || instr_ready;
   assign pc_inc_s    = pc_q + ADDR_W'(1'b1);

   assign imem_addr   = pc_q;
   assign instr_valid = instr_valid_q;
   assign instr_data  = instr_data_q;
   assign instr_pc    = instr_pc_q;

   // Branch beats everything; otherwise halt handling, then load or stall.
   always_comb begin
      pc_d          = pc_q;
      instr_valid_d = instr_valid_q;
      instr_data_d  = instr_data_q;
      instr_pc_d    = instr_pc_q;
`ifdef FETCH_HALT_DETECT_EN
      state_d       = state_q;
      halted_d      = halted_q;
`endif
      if (branch_valid) begin
         pc_d          = branch_target;
         instr_valid_d = 1'b0;
`ifdef FETCH_HALT_DETECT_EN
         state_d       = ST_FETCH;
         halted_d      = 1'b0;
`endif
      end
`ifdef FETCH_HALT_DETECT_EN
      else if (state_q == ST_HALT) begin
         instr_valid_d = instr_valid_q && !instr_ready;
         if (resume) begin
            pc_d     = pc_inc_s;
            state_d  = ST_FETCH;
            halted_d = 1'b0;
         end else begin
            pc_d     = pc_q;
         end
      end
`endif
      else if (slot_free_s) begin
`ifdef FETCH_HALT_DETECT_EN
         if (is_halt_s) begin
            // The halt word itself is never delivered; pc stays on it.
            instr_valid_d = 1'b0;
            state_d       = ST_HALT;
            halted_d      = 1'b1;
         end else begin
            instr_data_d  = imem_rd;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_inc_s;
         end
`else
         instr_data_d  = imem_rd;
         instr_pc_d    = pc_q;
         instr_valid_d = 1'b1;
         pc_d          = pc_inc_s;
`endif
      end else begin
         pc_d          = pc_q;
         instr_valid_d = instr_valid_q;
      end
   end

   // State and output slot registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         instr_valid_q <= 1'b0;
         instr_data_q  <= {DATA_W{1'b0}};
         instr_pc_q    <= {ADDR_W{1'b0}};
`ifdef FETCH_HALT_DETECT_EN
         state_q       <= ST_FETCH;
         halted_q      <= 1'b0;
`endif
      end else begin
         pc_q          <= pc_d;
         instr_valid_q <= instr_valid_d;
         instr_data_q  <= instr_data_d;
         instr_pc_q    <= instr_pc_d;
`ifdef FETCH_HALT_DETECT_EN
         state_q       <= state_d;
         halted_q      <= halted_d;
`endif
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: stimulus pushes expected deliveries, a monitor checks accepts.
module tb_fetch_ctrl;
   import cobra_pkg::*;

   typedef struct packed {
      logic [7:0]  pc;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rd;
   logic        branch_valid = 1'b0;
   logic [7:0]  branch_target = 8'h00;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr_data;
   logic [7:0]  instr_pc;
   logic        halted;
   logic        resume = 1'b0;

   logic [31:0] mem [256];
   exp_t        sb_q [$];
   int          checks = 0;
   int          failures = 0;

   assign imem_rd = mem[imem_addr];

   fetch_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_addr     (imem_addr),
      .imem_rd       (imem_rd),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr_data    (instr_data),
      .instr_pc      (instr_pc),
      .halted        (halted),
      .resume        (resume)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] a);
      sb_q.push_back('{pc: a, data: mem[a]});
   endtask

   // Monitor: every accepted instruction must match the next expected entry.
   always @(negedge clk) begin
      if (rst_n && instr_valid && instr_ready) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_accept_pc", {24'h0, instr_pc}, 32'hDEAD);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("accept_pc", {24'h0, instr_pc}, {24'h0, e.pc});
            chk("accept_data", instr_data, e.data);
         end
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0000_1000 + i;
      mem[0] = 32'd10;
      mem[1] = 32'd11;
      mem[2] = 32'd12;
      mem[3] = 32'd13;
`ifdef FETCH_HALT_DETECT_EN
      mem[5] = HALT_WORD;
`else
      mem[8'h80] = HALT_WORD;
`endif

      tick();
      tick();
      chk("rst_valid", {31'h0, instr_valid}, 32'h0);
      chk("rst_halted", {31'h0, halted}, 32'h0);
      chk("rst_addr", {24'h0, imem_addr}, 32'h0);
      chk("rst_data", instr_data, 32'h0);
      chk("rst_pc", {24'h0, instr_pc}, 32'h0);

      // Streaming from reset, then a three-cycle stall on pc 2.
      push(8'h00); push(8'h01); push(8'h02); push(8'h03);
      rst_n = 1'b1;
      instr_ready = 1'b1;
      tick();
      chk("first_valid", {31'h0, instr_valid}, 32'h1);
      chk("first_pc", {24'h0, instr_pc}, 32'h0);
      tick();
      chk("second_pc", {24'h0, instr_pc}, 32'h1);
      tick();
      chk("third_pc", {24'h0, instr_pc}, 32'h2);
      instr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_pc", {24'h0, instr_pc}, 32'h2);
         chk("stall_data", instr_data, 32'd12);
         chk("stall_addr", {24'h0, imem_addr}, 32'h3);
         chk("stall_valid", {31'h0, instr_valid}, 32'h1);
      end
      instr_ready = 1'b1;
      tick();
      chk("after_stall_pc", {24'h0, instr_pc}, 32'h3);
      tick();
      chk("pc4_shown", {24'h0, instr_pc}, 32'h4);
      instr_ready = 1'b0;
      tick();

      // Branch during stall drops pending pc 4.
      branch_valid = 1'b1;
      branch_target = 8'h40;
      tick();
      chk("flush_valid", {31'h0, instr_valid}, 32'h0);
      chk("flush_addr", {24'h0, imem_addr}, 32'h40);
      branch_valid = 1'b0;
      instr_ready = 1'b1;
      push(8'h40);
      tick();
      chk("branch_valid_out", {31'h0, instr_valid}, 32'h1);
      chk("branch_pc", {24'h0, instr_pc}, 32'h40);

      // Wrap-around from 0xFF to 0x00.
      branch_valid = 1'b1;
      branch_target = 8'hFE;
      tick();
      branch_valid = 1'b0;
      push(8'hFE); push(8'hFF); push(8'h00);
      tick();
      tick();
      chk("wrap_ff", {24'h0, instr_pc}, 32'hFF);
      tick();
      chk("wrap_00", {24'h0, instr_pc}, 32'h0);
      chk("wrap_addr", {24'h0, imem_addr}, 32'h1);

`ifdef FETCH_HALT_DETECT_EN
      branch_valid = 1'b1;
      branch_target = 8'h04;
      tick();
      branch_valid = 1'b0;
      push(8'h04);
      tick();
      chk("pre_halt_pc", {24'h0, instr_pc}, 32'h4);
      tick();
      chk("halt_halted", {31'h0, halted}, 32'h1);
      chk("halt_valid", {31'h0, instr_valid}, 32'h0);
      chk("halt_addr", {24'h0, imem_addr}, 32'h5);
      tick();
      chk("halt_hold_addr", {24'h0, imem_addr}, 32'h5);
      resume = 1'b1;
      tick();
      resume = 1'b0;
      chk("resume_halted", {31'h0, halted}, 32'h0);
      chk("resume_addr", {24'h0, imem_addr}, 32'h6);
      push(8'h06);
      tick();
      chk("resume_pc", {24'h0, instr_pc}, 32'h6);

      branch_valid = 1'b1;
      branch_target = 8'h05;
      tick();
      branch_valid = 1'b0;
      tick();
      chk("halt2_halted", {31'h0, halted}, 32'h1);
      branch_valid = 1'b1;
      branch_target = 8'h20;
      resume = 1'b1;
      tick();
      branch_valid = 1'b0;
      resume = 1'b0;
      chk("br_resume_halted", {31'h0, halted}, 32'h0);
      chk("br_resume_addr", {24'h0, imem_addr}, 32'h20);
      push(8'h20);
      tick();
      chk("br_resume_pc", {24'h0, instr_pc}, 32'h20);

      branch_valid = 1'b1;
      branch_target = 8'h05;
      tick();
      branch_valid = 1'b0;
      tick();
      chk("halt3_halted", {31'h0, halted}, 32'h1);
`else
      branch_valid = 1'b1;
      branch_target = 8'h80;
      tick();
      branch_valid = 1'b0;
      push(8'h80);
      tick();
      chk("ones_valid", {31'h0, instr_valid}, 32'h1);
      chk("ones_pc", {24'h0, instr_pc}, 32'h80);
      chk("ones_halted", {31'h0, halted}, 32'h0);
      tick();
      instr_ready = 1'b0;
      tick();
      chk("ones_stall_pc", {24'h0, instr_pc}, 32'h81);
`endif

      // Asynchronous reset mid-halt or mid-stall, then refetch from RESET_PC.
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'h0, instr_valid}, 32'h0);
      chk("arst_halted", {31'h0, halted}, 32'h0);
      chk("arst_addr", {24'h0, imem_addr}, 32'h0);
      tick();
      rst_n = 1'b1;
      instr_ready = 1'b1;
      push(8'h00);
      tick();
      chk("refetch_valid", {31'h0, instr_valid}, 32'h1);
      chk("refetch_pc", {24'h0, instr_pc}, 32'h0);
      tick();
      instr_ready = 1'b0;
      tick();
      chk("sb_empty", sb_q.size(), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, instruction address width (256-word instruction memory).
REQ-002 Parameter DATA_W, default 32, instruction word width.
REQ-003 Parameter RESET_PC, default 8'h00, PC value loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 imem_addr  output  ADDR_W  address to combinational-read instruction memory; equals PC register.
REQ-007 imem_rd  input  DATA_W  word read at imem_addr, valid in the same cycle.
REQ-008 branch_valid  input  1  redirect request, single-cycle qualifier.
REQ-009 branch_target  input  ADDR_W  redirect address, sampled when branch_valid=1.
REQ-010 instr_valid  output  1  instr_data/instr_pc hold a deliverable instruction.
REQ-011 instr_ready  input  1  decode accepts the instruction this cycle.
REQ-012 instr_data  output  DATA_W  registered instruction word.
REQ-013 instr_pc  output  ADDR_W  address of instr_data.
REQ-014 halted  output  1  fetch stopped on halt word.
REQ-015 resume  input  1  leave HALT, continue at halt address + 1.

Function
REQ-016 States: FETCH, HALT; only these two shall exist.
REQ-017 Output slot "free" = !instr_valid || instr_ready.
REQ-018 FETCH, no branch, slot free: load instr_data<=imem_rd, instr_pc<=pc, instr_valid<=1, pc<=pc+1.
REQ-019 FETCH, slot not free: pc, instr_data, instr_pc, instr_valid held unchanged (stall).
REQ-020 PC increment wraps modulo 2^ADDR_W (8'hFF -> 8'h00), no flag.
REQ-021 branch_valid=1 (any state): pc<=branch_target, instr_valid<=0 next cycle (flush), state<=FETCH; current imem_rd discarded.
REQ-022 Branch has priority over load, stall, halt detection and resume in the same cycle.
REQ-023 Branch while instr_valid=1 and instr_ready=0: slot flushed, undelivered instruction dropped.
REQ-024 Latency: instruction at address A appears on instr_valid the cycle after pc=A with slot free (1-cycle fetch).
REQ-025 Throughput: one instruction per cycle with instr_ready held high.
REQ-026 HALT: pc held, instr_valid<=0 after any pending accept, halted=1, imem_addr holds halt address.
REQ-027 HALT with resume=1: pc<=pc+1, state<=FETCH, halted<=0 next cycle.
REQ-028 resume in FETCH ignored.

Reset
REQ-029 rst_n low: pc=RESET_PC, state=FETCH, instr_valid=0, instr_data=0, instr_pc=0, halted=0, asynchronously.
REQ-030 Reset mid-stall or mid-HALT discards all state; first instr_valid=1 with instr_pc=RESET_PC one cycle after first clk edge with rst_n high.

Configuration
REQ-031 Macro FETCH_HALT_DETECT_EN.
REQ-032 Defined: slot-free load with imem_rd = all-ones does not deliver; state<=HALT, pc stays at that address, halted=1 next cycle.
REQ-033 Undefined: HALT state, halted and resume logic absent; halted tied 0; all-ones word delivered as normal instruction.

Structure
REQ-034 Shared package cobra_pkg: ADDR_W/DATA_W defaults, HALT_WORD constant (32'hFFFF_FFFF), fetch state enum.
REQ-035 No sub-module; single flat module, memory instantiated outside.

Verification
REQ-036 Reset release, mem[0..3]=10,11,12,13, instr_ready=1 -> instr_pc 0,1,2,3 on consecutive cycles, data matches.
REQ-037 instr_ready=0 for 3 cycles while instr_pc=2 -> instr_data/instr_pc/pc frozen; next accept delivers pc 3.
REQ-038 pc=8'hFF, ready=1 -> delivers 0xFF then 0x00.
REQ-039 Branch to 8'h40 during stall -> pending instr dropped, instr_valid=0 one cycle, next delivered instr_pc=8'h40.
REQ-040 (FETCH_HALT_DETECT_EN) mem[5]=HALT_WORD -> pc 4 delivered, halted=1, imem_addr=5; resume -> instr_pc=6; branch_valid+resume same cycle -> branch_target wins.
REQ-041 rst_n asserted while halted -> halted=0, instr_valid=0 immediately; refetch from RESET_PC.
